openila_decompress: RTL
=======================

// Module: openila_decompress
// PURPOSE
//  Readback-side expander for the simple-mode OpenILA sample stream. Consumes
//  W_MEM-bit codewords from capture memory: 0xxxx = literal sample, 1tttt =
//  previous sample held for t more cycles. Emits one raw W_SAMPLE sample per
//  output handshake, reconstructing the original per-cycle trace for the host.
//  Sits between the capture-RAM read port and the host/debug-bus sample FIFO.
// PARAMETERS
//  W_SAMPLE  8             raw sample width
//  W_COUNT   7             stable-count field width; must be <= W_SAMPLE
//  W_MEM     W_SAMPLE+1    codeword width; must equal W_SAMPLE+1
// PORTS
//  clk         in   1         clock
//  rst_n       in   1         reset; synchronous, active-low
//  cin         in   W_MEM     codeword; bit W_MEM-1 = type (0 literal, 1 stable)
//  cin_valid   in   1         codeword present
//  cin_ready   out  1         codeword accepted when cin_valid && cin_ready
//  dout        out  W_SAMPLE  reconstructed sample
//  dout_valid  out  1         sample present
//  dout_ready  in   1         sample consumed when dout_valid && dout_ready
//  busy        out  1         high while in REPEAT state
// BEHAVIOUR
//  - Reset (rst_n low at a clk edge): dout=0, dout_valid=0, busy=0,
//    last_sample=0, rem=0, state=IDLE. Applies mid-repeat; pending repeats dropped.
//  - All regs update on posedge clk only. Output slot free: fr = !dout_valid || dout_ready.
//  - cin_ready = (state==IDLE) && fr. Purely combinational from regs + dout_ready.
//  - If fr && no new load this cycle: dout_valid <= 0 (dout holds value).
//  - IDLE, accept literal: dout <= cin[W_SAMPLE-1:0]; last_sample <= same;
//    dout_valid <= 1. Latency 1 cycle accept->dout_valid.
//  - IDLE, accept stable, t = cin[W_COUNT-1:0]: dout <= last_sample; dout_valid <= 1;
//    rem <= t - 1 (W_COUNT-bit wrap). If t==1 stay IDLE, else -> REPEAT.
//    t==0 is counter overflow = 2^W_COUNT repeats (t-1 wraps to all ones).
//    Bits cin[W_MEM-2:W_COUNT] of a stable codeword are ignored.
//  - REPEAT, fr: dout <= last_sample; dout_valid <= 1; rem <= rem-1;
//    if rem==1 -> IDLE. REPEAT, !fr: hold everything.
//  - Result: stable code t accepted in cycle 0 with dout_ready=1 gives last_sample
//    on dout in cycles 1..t; cin_ready high again in cycle t; back-to-back
//    codewords sustain 1 sample/cycle with zero bubbles.
//  - Stable code before any literal repeats reset value 0 (matches the
//    compressor's reset din_prev).
//  - Backpressure: dout/dout_valid stable while dout_valid && !dout_ready; no
//    sample lost or duplicated; cin not accepted while output stalled.
//  - busy = (state==REPEAT). Single state bit + W_COUNT-bit rem counter.
// TESTING (W_SAMPLE=8, W_COUNT=7, W_MEM=9)
//  1 Reset: hold rst_n=0 3 cycles -> dout=0, dout_valid=0, cin_ready=1 after release.
//  2 Literals 0x0A5,0x03C back-to-back, dout_ready=1 -> dout A5,3C in
//    consecutive cycles, cin_ready stays 1.
//  3 Literal 0x011 then stable 0x103 then literal 0x022 -> dout 11,11,11,11,22
//    on 5 consecutive cycles; cin_ready low exactly 2 cycles.
//  4 Literal 0x07F then stable 0x100 -> 129 valid samples total: 7F then 128x 7F;
//    busy high 127 cycles.
//  5 Stable 0x105 accepted, dout_ready toggled 1,0,0,1,0,1... -> exactly 5
//    handshakes of value 0 (no prior literal), dout frozen during stalls.
//  6 Stable 0x150 accepted, rst_n pulsed low after 10 outputs -> dout_valid=0,
//    busy=0 next cycle; following literal 0x099 yields 99 with 1-cycle latency.
//  Bench also checks every handshake against a reference model of the code.

Source files
------------

// File: rtl/openila_decompress.sv
// Readback expander for simple-mode OpenILA codewords: literal samples pass through,
// stable codewords replay the previous sample t more times, one sample per output handshake.
module openila_decompress #(
  parameter int W_SAMPLE = 8,
  parameter int W_COUNT  = 7,
  parameter int W_MEM    = W_SAMPLE + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [W_MEM-1:0]    cin,
  input  logic                cin_valid,
  output logic                cin_ready,
  output logic [W_SAMPLE-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                busy
);

  typedef enum logic {IDLE = 1'b0, REPEAT = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [W_SAMPLE-1:0] last_sample, last_nxt;
  logic [W_COUNT-1:0]  rem, rem_nxt;
  logic [W_SAMPLE-1:0] dout_nxt;
  logic                vld_nxt;

  logic                fr;
  logic                accept;
  logic                is_stable;
  logic [W_COUNT-1:0]  t_cnt;

  assign fr        = !dout_valid || dout_ready;
  assign cin_ready = (state == IDLE) && fr;
  assign accept    = cin_valid && cin_ready;
  assign is_stable = cin[W_MEM-1];
  assign t_cnt     = cin[W_COUNT-1:0];
  assign busy      = (state == REPEAT);

  always_comb begin
    state_nxt = state;
    last_nxt  = last_sample;
    rem_nxt   = rem;
    dout_nxt  = dout;
    vld_nxt   = dout_valid;
    if (fr) vld_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          vld_nxt = 1'b1;
          if (is_stable) begin
            // t==0 wraps rem to all ones, giving 2^W_COUNT samples in total
            dout_nxt = last_sample;
            rem_nxt  = t_cnt - W_COUNT'(1);
            if (t_cnt != W_COUNT'(1)) state_nxt = REPEAT;
          end else begin
            dout_nxt = cin[W_SAMPLE-1:0];
            last_nxt = cin[W_SAMPLE-1:0];
          end
        end
      end
      REPEAT: begin
        if (fr) begin
          dout_nxt = last_sample;
          vld_nxt  = 1'b1;
          rem_nxt  = rem - W_COUNT'(1);
          if (rem == W_COUNT'(1)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output/state register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_sample <= '0;
      rem         <= '0;
      dout        <= '0;
      dout_valid  <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_sample <= last_nxt;
      rem         <= rem_nxt;
      dout        <= dout_nxt;
      dout_valid  <= vld_nxt;
    end
  end

endmodule
